// File: rtl/sisc_ctrl_fsm.sv
// SISC control sequencer: fetch/decode/execute/mem/writeback with data-memory
// handshake, conditional/relative branching and a sticky halt state.
module sisc_ctrl_fsm #(
    parameter int unsigned OP_W     = 4,
    parameter int unsigned CC_W     = 4,
    parameter int unsigned IMM_MM   = 8,
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [OP_W-1:0] opcode,
    input  logic [CC_W-1:0] mm,
    input  logic [CC_W-1:0] stat,
    input  logic            mem_rdy,
    output logic            ir_load,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            br_sel,
    output logic [1:0]      alu_op,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            dm_re,
    output logic            dm_we,
    output logic            halted,
    output logic            bad_op,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_START1    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEM       = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWP  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(15);

    localparam logic [CC_W-1:0] MM_IMM = CC_W'(IMM_MM);

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_SWAP = 2'b11;

    state_t cur_q;
    state_t nxt;

    logic is_noop, is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr;
    logic is_alu, is_hlt, is_bad, is_br, cc_hit, br_taken;
    logic [1:0] exe_alu_op;

    // Full-width compares: any set bit above the 4-bit code makes the opcode undefined.
    assign is_noop = (opcode == OP_NOOP);
    assign is_lod  = (opcode == OP_LOD);
    assign is_str  = (opcode == OP_STR);
    assign is_swp  = (opcode == OP_SWP);
    assign is_bra  = (opcode == OP_BRA);
    assign is_brr  = (opcode == OP_BRR);
    assign is_bne  = (opcode == OP_BNE);
    assign is_bnr  = (opcode == OP_BNR);
    assign is_alu  = (opcode == OP_ALU);
    assign is_hlt  = (opcode == OP_HLT);
    assign is_br   = is_bra | is_brr | is_bne | is_bnr;
    assign is_bad  = ~(is_noop | is_lod | is_str | is_swp | is_br | is_alu | is_hlt);

    assign cc_hit   = |(mm & stat);
    assign br_taken = (is_bra | is_brr) ? cc_hit : ~cc_hit;

    // ALU mode chosen in EXECUTE and held through WRITEBACK.
    always_comb begin
        exe_alu_op = ALU_PASS;
        if (is_alu)
            exe_alu_op = (mm == MM_IMM) ? ALU_IMM : ALU_RR;
        else if (is_lod | is_str)
            exe_alu_op = ALU_IMM;
        else if (is_swp)
            exe_alu_op = ALU_SWAP;
    end

    always_ff @(posedge clk) begin
        if (rst_f)
            cur_q <= ST_START0;
        else
            cur_q <= nxt;
    end

    always_comb begin
        nxt      = cur_q;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        alu_op   = ALU_PASS;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        halted   = 1'b0;
        bad_op   = 1'b0;
        case (cur_q)
            ST_START0: nxt = ST_START1;
            ST_START1: nxt = ST_FETCH;
            ST_FETCH: begin
                nxt      = ST_DECODE;
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            ST_DECODE: begin
                nxt    = is_hlt ? ST_HALT : ST_EXECUTE;
                bad_op = is_bad;
            end
            ST_EXECUTE: begin
                alu_op = exe_alu_op;
                if (is_lod | is_str)
                    nxt = ST_MEM;
                else if (is_alu | is_swp)
                    nxt = ST_WRITEBACK;
                else
                    nxt = ST_FETCH;
                if (is_br) begin
                    br_sel = is_brr | is_bnr;
                    if (br_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                alu_op = ALU_IMM;
                dm_re  = is_lod;
                dm_we  = is_str;
                if ((MEM_WAIT != 0) && !mem_rdy)
                    nxt = ST_MEM;
                else
                    nxt = is_lod ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: begin
                nxt    = ST_FETCH;
                rf_we  = 1'b1;
                wb_sel = is_lod;
                alu_op = exe_alu_op;
            end
            ST_HALT: begin
                nxt    = ST_HALT;
                halted = 1'b1;
            end
            default: nxt = ST_START0;
        endcase
    end

    assign state = cur_q;

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Directed bench for sisc_ctrl_fsm; outputs are packed into a 12-bit vector
// {ir_load,pc_write,pc_sel,br_sel,alu_op[1:0],rf_we,wb_sel,dm_re,dm_we,halted,bad_op}.
module tb_sisc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       mem_rdy;
    logic       ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel;
    logic       dm_re, dm_we, halted, bad_op;
    logic [1:0] alu_op;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [11:0] O_IDLE    = 12'h080;
    localparam logic [11:0] O_FETCH   = 12'hC80;
    localparam logic [11:0] O_BAD     = 12'h081;
    localparam logic [11:0] O_EX_IMM  = 12'h040;
    localparam logic [11:0] O_EX_RR   = 12'h000;
    localparam logic [11:0] O_WB_IMM  = 12'h060;
    localparam logic [11:0] O_WB_RR   = 12'h020;
    localparam logic [11:0] O_MEM_LOD = 12'h048;
    localparam logic [11:0] O_MEM_STR = 12'h044;
    localparam logic [11:0] O_WB_LOD  = 12'h070;
    localparam logic [11:0] O_EX_SWP  = 12'h0C0;
    localparam logic [11:0] O_WB_SWP  = 12'h0E0;
    localparam logic [11:0] O_BR_REL  = 12'h780;
    localparam logic [11:0] O_BR_ABS  = 12'h680;
    localparam logic [11:0] O_HALT    = 12'h082;

    sisc_ctrl_fsm dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .mem_rdy  (mem_rdy),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .alu_op   (alu_op),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .halted   (halted),
        .bad_op   (bad_op),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_st, input logic [11:0] exp_out);
        logic [11:0] obs;
        obs = {ir_load, pc_write, pc_sel, br_sel, alu_op, rf_we, wb_sel, dm_re, dm_we, halted, bad_op};
        tests_run++;
        assert (state === exp_st) else begin
            tests_failed++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
        end
        tests_run++;
        assert (obs === exp_out) else begin
            tests_failed++;
            $error("FAIL %s outputs: got %03h expected %03h", tag, obs, exp_out);
        end
    endtask

    initial begin
        rst_f = 1'b1; opcode = 4'd8; mm = 4'd8; stat = 4'd0; mem_rdy = 1'b0;
        tick(); tick();
        chk("reset", 3'd0, O_IDLE);
        rst_f = 1'b0;
        tick(); chk("start1", 3'd1, O_IDLE);
        tick(); chk("fetch0", 3'd2, O_FETCH);

        // ALU immediate, then register-register
        tick(); chk("alu_imm_dec", 3'd3, O_IDLE);
        tick(); chk("alu_imm_ex", 3'd4, O_EX_IMM);
        tick(); chk("alu_imm_wb", 3'd6, O_WB_IMM);
        tick(); chk("alu_imm_fetch", 3'd2, O_FETCH);
        mm = 4'd0;
        tick(); chk("alu_rr_dec", 3'd3, O_IDLE);
        tick(); chk("alu_rr_ex", 3'd4, O_EX_RR);
        tick(); chk("alu_rr_wb", 3'd6, O_WB_RR);
        tick(); chk("alu_rr_fetch", 3'd2, O_FETCH);

        // LOD with three wait cycles
        opcode = 4'd1;
        tick(); chk("lod_dec", 3'd3, O_IDLE);
        tick(); chk("lod_ex", 3'd4, O_EX_IMM);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lod_mem_wait", 3'd5, O_MEM_LOD);
            tick();
        end
        mem_rdy = 1'b1;
        chk("lod_mem_last", 3'd5, O_MEM_LOD);
        tick(); mem_rdy = 1'b0;
        chk("lod_wb", 3'd6, O_WB_LOD);
        tick(); chk("lod_fetch", 3'd2, O_FETCH);

        // STR with three wait cycles
        opcode = 4'd2;
        tick(); chk("str_dec", 3'd3, O_IDLE);
        tick(); chk("str_ex", 3'd4, O_EX_IMM);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("str_mem_wait", 3'd5, O_MEM_STR);
            tick();
        end
        mem_rdy = 1'b1;
        chk("str_mem_last", 3'd5, O_MEM_STR);
        tick(); chk("str_fetch", 3'd2, O_FETCH);

        // STR with mem_rdy high throughout: ignored outside MEM, zero wait
        tick(); chk("str0_dec", 3'd3, O_IDLE);
        tick(); chk("str0_ex", 3'd4, O_EX_IMM);
        tick(); chk("str0_mem", 3'd5, O_MEM_STR);
        tick(); chk("str0_fetch", 3'd2, O_FETCH);
        mem_rdy = 1'b0;

        // SWP
        opcode = 4'd3;
        tick(); chk("swp_dec", 3'd3, O_IDLE);
        tick(); chk("swp_ex", 3'd4, O_EX_SWP);
        tick(); chk("swp_wb", 3'd6, O_WB_SWP);
        tick(); chk("swp_fetch", 3'd2, O_FETCH);

        // Branches with stat=0100
        stat = 4'b0100;
        opcode = 4'd5; mm = 4'b0100;
        tick(); chk("brr_dec", 3'd3, O_IDLE);
        tick(); chk("brr_taken_ex", 3'd4, O_BR_REL);
        tick(); chk("brr_fetch", 3'd2, O_FETCH);
        opcode = 4'd4; mm = 4'b0010;
        tick(); tick(); chk("bra_not_taken_ex", 3'd4, O_IDLE);
        tick(); chk("bra_fetch", 3'd2, O_FETCH);
        opcode = 4'd6; mm = 4'b0010;
        tick(); tick(); chk("bne_taken_ex", 3'd4, O_BR_ABS);
        tick(); chk("bne_fetch", 3'd2, O_FETCH);
        opcode = 4'd7; mm = 4'b0000;
        tick(); tick(); chk("bnr_mm0_ex", 3'd4, O_BR_REL);
        tick(); chk("bnr_fetch", 3'd2, O_FETCH);
        opcode = 4'd4; mm = 4'b0000; stat = 4'b1111;
        tick(); tick(); chk("bra_mm0_ex", 3'd4, O_IDLE);
        tick(); chk("bra_mm0_fetch", 3'd2, O_FETCH);

        // Undefined opcode
        opcode = 4'd9;
        tick(); chk("undef_dec", 3'd3, O_BAD);
        tick(); chk("undef_ex", 3'd4, O_IDLE);
        tick(); chk("undef_fetch", 3'd2, O_FETCH);

        // HLT is sticky until reset
        opcode = 4'd15;
        tick(); chk("hlt_dec", 3'd3, O_IDLE);
        tick(); chk("hlt_enter", 3'd7, O_HALT);
        for (int i = 0; i < 10; i++) begin
            tick(); chk("hlt_sticky", 3'd7, O_HALT);
        end
        rst_f = 1'b1;
        tick(); chk("hlt_reset", 3'd0, O_IDLE);
        rst_f = 1'b0;
        tick(); chk("hlt_start1", 3'd1, O_IDLE);
        tick(); chk("hlt_refetch", 3'd2, O_FETCH);

        // Reset during a MEM wait
        opcode = 4'd1; mem_rdy = 1'b0;
        tick(); tick(); tick();
        chk("rst_mem_enter", 3'd5, O_MEM_LOD);
        tick(); chk("rst_mem_wait", 3'd5, O_MEM_LOD);
        rst_f = 1'b1;
        tick(); chk("rst_mid_mem", 3'd0, O_IDLE);
        rst_f = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
